pool_arb: RTL and testbench
===========================

# pool_arb

Registered, parametrised successor to the stamp/take pool collector. Gathers per-register stamp and take requests from `N_SRC` execution units (alu, fpu, imm, jump, mov, …) into a single conveyor write-back stream. Each register lane is arbitrated independently, and losers are held back by a per-source acknowledge rather than silently overwritten. Output is a registered valid/ready stage toward the conveyor, and conflicts are counted for performance monitoring.

## Interface
- `N_SRC`, 5, number of requesting units; index 0 = alu … 4 = mov
- `LANES`, 8, register lanes (a–h)
- `STAMP_W`, 3, stamp field width
- `TAKE_W`, 5, take field width
- `RR_MODE`, 0, 0 = fixed priority (highest source index wins); 1 = round-robin per lane
- `CNT_W`, 16, conflict counter width
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `src_stamp_flat`  in  N_SRC·LANES·STAMP_W  stamp for source s, lane l at bit offset (s·LANES+l)·STAMP_W
- `src_stamp_in`  in  N_SRC·LANES  stamp request (potential), bit s·LANES+l
- `src_take_flat`  in  N_SRC·LANES·TAKE_W  take, same packing with TAKE_W
- `src_take_in`  in  N_SRC·LANES  take request
- `src_stamp_ack`  out  N_SRC·LANES  stamp request accepted this cycle
- `src_take_ack`  out  N_SRC·LANES  take request accepted this cycle
- `conveyor_stamp_flat`  out  LANES·STAMP_W  registered stamp per lane
- `conveyor_stamp_in`  out  LANES  stamp valid per lane
- `conveyor_take_flat`  out  LANES·TAKE_W  registered take per lane
- `conveyor_take_in`  out  LANES  take valid per lane
- `conveyor_ready`  in  1  conveyor consumes all valid lanes this cycle
- `conflict_cnt`  out  CNT_W  saturating count of lane-arbitrations with more than one requester

## Operation
- Stamp and take are separate channels. Each (channel, lane) pair is arbitrated independently. A source may win stamp and lose take on the same lane.
- Lane load enable: `load[l] = !valid[l] || conveyor_ready`, evaluated per channel.
- Grant:
  - `RR_MODE=0`: the highest-index requesting source wins, so mov beats jump beats imm beats fpu beats alu.
  - `RR_MODE=1`: each (channel, lane) keeps a pointer `ptr` (log2 N_SRC bits). The search starts at `ptr`, increasing index with wrap. After a loaded grant, `ptr` ← winner+1 mod N_SRC.
- Ack is combinational: `ack = grant & load`. An unacked source must hold its request and data stable. The block keeps no per-source state.
- On load with a winner: output field ← winner data, valid ← 1.
- On load with no requester: valid ← 0, and the field holds its old value.
- While valid=1 and `conveyor_ready`=0, the lane holds its field and valid, issues no acks, and leaves `ptr` unchanged.
- Conflict counting: `conflict_cnt` += number of (channel, lane) pairs where load=1 and requester count ≥ 2. It saturates at all-ones and does not wrap.

## Timing
- Reset: all valids 0, all fields 0, all `ptr` 0, `conflict_cnt` 0. Acks are 0 during reset regardless of requests.
- Request-to-output latency is 1 cycle: the request is acked in cycle N and the output is valid in cycle N+1.
- Full throughput: with `conveyor_ready`=1, one grant per (channel, lane) every cycle.
- When requests are ready-gated, the lane stalls. New requests arriving during the stall are arbitrated on the first cycle `conveyor_ready`=1, using the current `ptr`.
- Reset asserted mid-stall: held outputs are dropped, with valid=0 on the next cycle. Sources re-present their requests after reset.
- Round-robin wrap: with `ptr`=N_SRC−1 and that source granted, `ptr` → 0.

## Structure
- `pool_pkg`: default widths, the `RR_MODE` encodings, and functions for flat offsets (stamp/take index helpers).
- Sub-module `pool_lane_arb #(N_SRC, W, RR_MODE)`:
  - one (channel, lane) arbiter with its output register and pointer
  - exposes the grant vector and a conflict flag
  - instantiated LANES×2 via generate
- The top level slices the flat buses, and sums the conflict flags into the saturating counter.

## Test plan
- Single request: alu stamp lane 2 = 3'd5 with ready=1 → ack the same cycle; next cycle `conveyor_stamp_in`=8'b00000100 and field[2]=5.
- Fixed priority: `RR_MODE=0`, alu and mov both take lane 0 (5'd1 vs 5'd9) → mov acked, output 9. alu holds its request → acked the following cycle, output 1. `conflict_cnt` = 1.
- Round-robin: `RR_MODE=1`, all 5 sources hold stamp lane 7 for 6 cycles → grants 0,1,2,3,4,0. `conflict_cnt` = 6.
- Backpressure: valid lane 3 with ready=0 for 4 cycles while imm requests → no acks, output unchanged. Ready=1 → imm acked, new value next cycle.
- Mixed channels: fpu stamp and jump take on lane 4 in the same cycle → both acked, both valid next cycle, no conflict counted.
- Saturation and reset: `CNT_W=2`, 5 conflict cycles → counter reads 3. Assert `rst` mid-stall → all outputs 0 next cycle, counter 0.

Source files
------------

// File: rtl/pool_arb_pkg.sv
// rtl/pool_arb_pkg.sv - default widths, arbitration mode encodings and flat-bus offset helpers
package pool_pkg;

   localparam int DEF_N_SRC   = 5;
   localparam int DEF_LANES   = 8;
   localparam int DEF_STAMP_W = 3;
   localparam int DEF_TAKE_W  = 5;
   localparam int DEF_CNT_W   = 16;

   // arbitration modes: fixed priority (highest source index wins) or per-lane round-robin
   localparam int RR_FIXED = 0;
   localparam int RR_ROUND = 1;

   // bit index of the request/ack flag for source s, lane l
   function automatic int req_idx(input int s, input int l, input int lanes);
      return s * lanes + l;
   endfunction

   // bit offset of the w-wide field for source s, lane l
   function automatic int fld_off(input int s, input int l, input int lanes, input int w);
      return (s * lanes + l) * w;
   endfunction

endpackage

// File: rtl/pool_arb_if.sv
// rtl/pool_arb_if.sv - source request bus and conveyor write-back bus
interface pool_arb_if
   import pool_pkg::*;
#(
   parameter int N_SRC   = DEF_N_SRC,
   parameter int LANES   = DEF_LANES,
   parameter int STAMP_W = DEF_STAMP_W,
   parameter int TAKE_W  = DEF_TAKE_W
);
   logic [N_SRC*LANES*STAMP_W-1:0] src_stamp_flat;
   logic [N_SRC*LANES-1:0]         src_stamp_in;
   logic [N_SRC*LANES*TAKE_W-1:0]  src_take_flat;
   logic [N_SRC*LANES-1:0]         src_take_in;
   logic [N_SRC*LANES-1:0]         src_stamp_ack;
   logic [N_SRC*LANES-1:0]         src_take_ack;
   logic [LANES*STAMP_W-1:0]       conveyor_stamp_flat;
   logic [LANES-1:0]               conveyor_stamp_in;
   logic [LANES*TAKE_W-1:0]        conveyor_take_flat;
   logic [LANES-1:0]               conveyor_take_in;
   logic                           conveyor_ready;

   modport master (
      output src_stamp_flat, src_stamp_in, src_take_flat, src_take_in, conveyor_ready,
      input  src_stamp_ack, src_take_ack,
      input  conveyor_stamp_flat, conveyor_stamp_in, conveyor_take_flat, conveyor_take_in
   );

   modport slave (
      input  src_stamp_flat, src_stamp_in, src_take_flat, src_take_in, conveyor_ready,
      output src_stamp_ack, src_take_ack,
      output conveyor_stamp_flat, conveyor_stamp_in, conveyor_take_flat, conveyor_take_in
   );
endinterface

// File: rtl/pool_arb_lane_arb.sv
// rtl/pool_arb_lane_arb.sv - one (channel, lane) arbiter with output register and rr pointer
module pool_lane_arb
   import pool_pkg::*;
#(
   parameter int N_SRC   = DEF_N_SRC,
   parameter int W       = DEF_STAMP_W,
   parameter int RR_MODE = RR_FIXED
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_SRC-1:0]   req,
   input  logic [N_SRC*W-1:0] data,
   input  logic               ready,
   output logic [N_SRC-1:0]   ack,
   output logic               conflict,
   output logic               valid,
   output logic [W-1:0]       field
);
   localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   logic [PW-1:0]    ptr;
   logic [PW-1:0]    ptr_nxt;
   logic [PW-1:0]    win;
   logic [PW:0]      cand;
   logic             found;
   logic             load;
   logic [N_SRC-1:0] grant;
   logic [W-1:0]     sel;
   int               nreq;

   // winner search, requester count, ack gating and next pointer
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      nreq  = 0;
      sel   = '0;
      for (int k = 0; k < N_SRC; k++) begin
         if (req[k]) nreq = nreq + 1;
      end
      if (RR_MODE == RR_ROUND) begin
         for (int k = 0; k < N_SRC; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(N_SRC)) cand = cand - (PW+1)'(N_SRC);
            if (!found && req[cand[PW-1:0]]) begin
               found = 1'b1;
               win   = cand[PW-1:0];
            end
         end
      end else begin
         for (int k = 0; k < N_SRC; k++) begin
            if (req[k]) begin
               found = 1'b1;
               win   = PW'(k);
            end
         end
      end
      for (int k = 0; k < N_SRC; k++) begin
         if (PW'(k) == win) sel = data[k*W +: W];
      end
      grant    = found ? (N_SRC'(1) << win) : '0;
      load     = !rst && (!valid || ready);
      ack      = grant & {N_SRC{load}};
      conflict = load && (nreq >= 2);
      ptr_nxt  = (win == PW'(N_SRC - 1)) ? '0 : win + PW'(1);
   end

   // output register: load winner data, drop valid when idle, hold while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         field <= '0;
         ptr   <= '0;
      end else if (load) begin
         if (found) begin
            valid <= 1'b1;
            field <= sel;
            if (RR_MODE == RR_ROUND) ptr <= ptr_nxt;
         end else begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pool_arb.sv
// rtl/pool_arb.sv - per-lane stamp/take arbitration into the conveyor write-back stream
module pool_arb
   import pool_pkg::*;
#(
   parameter int N_SRC   = DEF_N_SRC,
   parameter int LANES   = DEF_LANES,
   parameter int STAMP_W = DEF_STAMP_W,
   parameter int TAKE_W  = DEF_TAKE_W,
   parameter int RR_MODE = RR_FIXED,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   pool_arb_if.slave        bus,
   output logic [CNT_W-1:0] conflict_cnt
);
   localparam int SUM_W = CNT_W + $clog2(2 * LANES + 1) + 1;

   logic [LANES-1:0] st_conf;
   logic [LANES-1:0] tk_conf;
   logic [SUM_W-1:0] sum;

   genvar l, s;
   generate
      for (l = 0; l < LANES; l++) begin : g_lane
         logic [N_SRC-1:0]         st_req, tk_req, st_ack, tk_ack;
         logic [N_SRC*STAMP_W-1:0] st_data;
         logic [N_SRC*TAKE_W-1:0]  tk_data;
         logic                     st_valid, tk_valid;
         logic [STAMP_W-1:0]       st_field;
         logic [TAKE_W-1:0]        tk_field;

         for (s = 0; s < N_SRC; s++) begin : g_src
            assign st_req[s] = bus.src_stamp_in[req_idx(s, l, LANES)];
            assign tk_req[s] = bus.src_take_in[req_idx(s, l, LANES)];
            assign st_data[s*STAMP_W +: STAMP_W] =
               bus.src_stamp_flat[fld_off(s, l, LANES, STAMP_W) +: STAMP_W];
            assign tk_data[s*TAKE_W +: TAKE_W] =
               bus.src_take_flat[fld_off(s, l, LANES, TAKE_W) +: TAKE_W];
            assign bus.src_stamp_ack[req_idx(s, l, LANES)] = st_ack[s];
            assign bus.src_take_ack[req_idx(s, l, LANES)]  = tk_ack[s];
         end

         pool_lane_arb #(.N_SRC(N_SRC), .W(STAMP_W), .RR_MODE(RR_MODE)) u_stamp (
            .clk(clk), .rst(rst), .req(st_req), .data(st_data), .ready(bus.conveyor_ready),
            .ack(st_ack), .conflict(st_conf[l]), .valid(st_valid), .field(st_field)
         );

         pool_lane_arb #(.N_SRC(N_SRC), .W(TAKE_W), .RR_MODE(RR_MODE)) u_take (
            .clk(clk), .rst(rst), .req(tk_req), .data(tk_data), .ready(bus.conveyor_ready),
            .ack(tk_ack), .conflict(tk_conf[l]), .valid(tk_valid), .field(tk_field)
         );

         assign bus.conveyor_stamp_in[l]                    = st_valid;
         assign bus.conveyor_take_in[l]                     = tk_valid;
         assign bus.conveyor_stamp_flat[l*STAMP_W +: STAMP_W] = st_field;
         assign bus.conveyor_take_flat[l*TAKE_W +: TAKE_W]    = tk_field;
      end
   endgenerate

   // total of this cycle's conflict flags added to the running count
   always_comb begin
      sum = SUM_W'(conflict_cnt);
      for (int i = 0; i < LANES; i++) begin
         sum = sum + SUM_W'(st_conf[i]) + SUM_W'(tk_conf[i]);
      end
   end

   // saturating conflict counter
   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_cnt <= '0;
      end else if (sum > SUM_W'({CNT_W{1'b1}})) begin
         conflict_cnt <= '1;
      end else begin
         conflict_cnt <= sum[CNT_W-1:0];
      end
   end

endmodule

// File: tb/tb_pool_arb.sv
// tb/tb_pool_arb.sv - directed scoreboard bench for pool_arb in fixed, round-robin and narrow-counter builds
module tb_pool_arb;
   localparam int N  = 5;
   localparam int L  = 8;
   localparam int SW = 3;
   localparam int TW = 5;

   logic clk = 1'b0;
   logic rst;
   logic ready;
   logic [N*L*SW-1:0] st_flat;
   logic [N*L-1:0]    st_in;
   logic [N*L*TW-1:0] tk_flat;
   logic [N*L-1:0]    tk_in;

   logic [15:0] cnt_f, cnt_r;
   logic [1:0]  cnt_s;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pool_arb_if #(.N_SRC(N), .LANES(L), .STAMP_W(SW), .TAKE_W(TW)) if_f ();
   pool_arb_if #(.N_SRC(N), .LANES(L), .STAMP_W(SW), .TAKE_W(TW)) if_r ();
   pool_arb_if #(.N_SRC(N), .LANES(L), .STAMP_W(SW), .TAKE_W(TW)) if_s ();

   pool_arb #(.N_SRC(N), .LANES(L), .STAMP_W(SW), .TAKE_W(TW), .RR_MODE(0), .CNT_W(16)) dut_f (
      .clk(clk), .rst(rst), .bus(if_f), .conflict_cnt(cnt_f));
   pool_arb #(.N_SRC(N), .LANES(L), .STAMP_W(SW), .TAKE_W(TW), .RR_MODE(1), .CNT_W(16)) dut_r (
      .clk(clk), .rst(rst), .bus(if_r), .conflict_cnt(cnt_r));
   pool_arb #(.N_SRC(N), .LANES(L), .STAMP_W(SW), .TAKE_W(TW), .RR_MODE(0), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .bus(if_s), .conflict_cnt(cnt_s));

   assign if_f.src_stamp_flat = st_flat;
   assign if_f.src_stamp_in   = st_in;
   assign if_f.src_take_flat  = tk_flat;
   assign if_f.src_take_in    = tk_in;
   assign if_f.conveyor_ready = ready;
   assign if_r.src_stamp_flat = st_flat;
   assign if_r.src_stamp_in   = st_in;
   assign if_r.src_take_flat  = tk_flat;
   assign if_r.src_take_in    = tk_in;
   assign if_r.conveyor_ready = ready;
   assign if_s.src_stamp_flat = st_flat;
   assign if_s.src_stamp_in   = st_in;
   assign if_s.src_take_flat  = tk_flat;
   assign if_s.src_take_in    = tk_in;
   assign if_s.conveyor_ready = ready;

   // observed outputs indexed by build: 0 fixed, 1 round-robin, 2 narrow counter
   logic [L*SW-1:0] o_sf [3];
   logic [L-1:0]    o_sv [3];
   logic [L*TW-1:0] o_tf [3];
   logic [L-1:0]    o_tv [3];
   logic [N*L-1:0]  o_sa [3];
   logic [N*L-1:0]  o_ta [3];
   logic [15:0]     o_cnt[3];

   assign o_sf[0] = if_f.conveyor_stamp_flat;
   assign o_sv[0] = if_f.conveyor_stamp_in;
   assign o_tf[0] = if_f.conveyor_take_flat;
   assign o_tv[0] = if_f.conveyor_take_in;
   assign o_sa[0] = if_f.src_stamp_ack;
   assign o_ta[0] = if_f.src_take_ack;
   assign o_cnt[0] = cnt_f;
   assign o_sf[1] = if_r.conveyor_stamp_flat;
   assign o_sv[1] = if_r.conveyor_stamp_in;
   assign o_tf[1] = if_r.conveyor_take_flat;
   assign o_tv[1] = if_r.conveyor_take_in;
   assign o_sa[1] = if_r.src_stamp_ack;
   assign o_ta[1] = if_r.src_take_ack;
   assign o_cnt[1] = cnt_r;
   assign o_sf[2] = if_s.conveyor_stamp_flat;
   assign o_sv[2] = if_s.conveyor_stamp_in;
   assign o_tf[2] = if_s.conveyor_take_flat;
   assign o_tv[2] = if_s.conveyor_take_in;
   assign o_sa[2] = if_s.src_stamp_ack;
   assign o_ta[2] = if_s.src_take_ack;
   assign o_cnt[2] = 16'(cnt_s);

   typedef struct {
      int dut;
      bit tk;
      int lane;
      int val;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int d, input bit tk, input int l, input int v);
      exp_t e;
      e.dut = d; e.tk = tk; e.lane = l; e.val = v;
      sb.push_back(e);
   endtask

   task automatic sb_check();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.tk) begin
            chk($sformatf("d%0d take valid l%0d", e.dut, e.lane), 64'(o_tv[e.dut][e.lane]), 64'd1);
            chk($sformatf("d%0d take field l%0d", e.dut, e.lane),
                64'(o_tf[e.dut][e.lane*TW +: TW]), 64'(e.val));
         end else begin
            chk($sformatf("d%0d stamp valid l%0d", e.dut, e.lane), 64'(o_sv[e.dut][e.lane]), 64'd1);
            chk($sformatf("d%0d stamp field l%0d", e.dut, e.lane),
                64'(o_sf[e.dut][e.lane*SW +: SW]), 64'(e.val));
         end
      end
   endtask

   function automatic logic [63:0] bitv(input int s, input int l);
      logic [63:0] v;
      v = '0;
      v[s*L+l] = 1'b1;
      return v;
   endfunction

   task automatic put_st(input int s, input int l, input int v);
      st_in[s*L+l] = 1'b1;
      st_flat[(s*L+l)*SW +: SW] = SW'(v);
   endtask

   task automatic put_tk(input int s, input int l, input int v);
      tk_in[s*L+l] = 1'b1;
      tk_flat[(s*L+l)*TW +: TW] = TW'(v);
   endtask

   task automatic clr();
      st_in = '0;
      tk_in = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clr();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ready = 1'b1;
      st_flat = '0; tk_flat = '0; clr();

      // reset: a pending request is never acked, outputs start cleared
      put_st(0, 2, 5);
      #2;
      chk("ack in reset", 64'(o_sa[0]), 64'd0);
      tick();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("d%0d reset stamp valid", d), 64'(o_sv[d]), 64'd0);
         chk($sformatf("d%0d reset stamp field", d), 64'(o_sf[d]), 64'd0);
         chk($sformatf("d%0d reset take valid", d), 64'(o_tv[d]), 64'd0);
         chk($sformatf("d%0d reset take field", d), 64'(o_tf[d]), 64'd0);
         chk($sformatf("d%0d reset cnt", d), 64'(o_cnt[d]), 64'd0);
      end
      rst = 1'b0; clr();

      // single request: alu stamp lane 2 = 5
      put_st(0, 2, 5);
      #1;
      chk("single ack", 64'(o_sa[0]), bitv(0, 2));
      push(0, 0, 2, 5); push(1, 0, 2, 5);
      tick(); clr();
      sb_check();
      chk("single stamp_in", 64'(o_sv[0]), 64'b00000100);
      tick();
      chk("idle valid drop", 64'(o_sv[0]), 64'd0);
      chk("idle field hold", 64'(o_sf[0][2*SW +: SW]), 64'd5);

      // fixed priority: mov beats alu on take lane 0, alu follows
      put_tk(0, 0, 1); put_tk(4, 0, 9);
      #1;
      chk("prio mov ack", 64'(o_ta[0]), bitv(4, 0));
      push(0, 1, 0, 9);
      tick();
      sb_check();
      tk_in[4*L+0] = 1'b0;
      #1;
      chk("prio alu ack", 64'(o_ta[0]), bitv(0, 0));
      push(0, 1, 0, 1);
      tick(); clr();
      sb_check();
      chk("prio cnt", 64'(o_cnt[0]), 64'd1);

      // round-robin: every source holds stamp lane 7 for 6 cycles
      do_reset();
      for (int k = 0; k < 6; k++) begin
         for (int s = 0; s < N; s++) put_st(s, 7, s + 1);
         #1;
         chk($sformatf("rr ack cycle %0d", k), 64'(o_sa[1]), bitv(k % N, 7));
         push(1, 0, 7, (k % N) + 1);
         push(0, 0, 7, N);
         tick();
         sb_check();
      end
      clr();
      chk("rr cnt", 64'(o_cnt[1]), 64'd6);
      chk("rr fixed cnt", 64'(o_cnt[0]), 64'd6);

      // backpressure: lane 3 stalls four cycles while imm waits
      do_reset();
      put_st(0, 3, 2);
      #1;
      chk("bp load ack", 64'(o_sa[0]), bitv(0, 3));
      push(0, 0, 3, 2);
      tick(); clr();
      sb_check();
      ready = 1'b0;
      put_st(2, 3, 6);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("bp stall ack %0d", k), 64'(o_sa[0]), 64'd0);
         tick();
         chk($sformatf("bp hold valid %0d", k), 64'(o_sv[0][3]), 64'd1);
         chk($sformatf("bp hold field %0d", k), 64'(o_sf[0][3*SW +: SW]), 64'd2);
      end
      ready = 1'b1;
      #1;
      chk("bp release ack", 64'(o_sa[0]), bitv(2, 3));
      push(0, 0, 3, 6);
      tick(); clr();
      sb_check();

      // mixed channels on lane 4: fpu stamp and jump take both win
      do_reset();
      put_st(1, 4, 3); put_tk(3, 4, 17);
      #1;
      chk("mix stamp ack", 64'(o_sa[0]), bitv(1, 4));
      chk("mix take ack", 64'(o_ta[0]), bitv(3, 4));
      push(0, 0, 4, 3); push(0, 1, 4, 17);
      tick(); clr();
      sb_check();
      chk("mix cnt", 64'(o_cnt[0]), 64'd0);

      // saturation on the 2-bit counter, then reset during a stall
      do_reset();
      for (int k = 0; k < 5; k++) begin
         put_st(0, 1, 1); put_st(4, 1, 7);
         tick();
      end
      clr();
      chk("sat cnt", 64'(o_cnt[2]), 64'd3);
      chk("wide cnt", 64'(o_cnt[0]), 64'd5);
      ready = 1'b0;
      put_st(0, 1, 1);
      #1;
      chk("sat stall ack", 64'(o_sa[2]), 64'd0);
      tick();
      chk("sat stall valid", 64'(o_sv[2]), 64'b00000010);
      chk("sat stall field", 64'(o_sf[2][1*SW +: SW]), 64'd7);
      rst = 1'b1; ready = 1'b1;
      #1;
      chk("rst ack mask", 64'(o_sa[2]), 64'd0);
      tick();
      chk("rst drop valid", 64'(o_sv[2]), 64'd0);
      chk("rst drop field", 64'(o_sf[2]), 64'd0);
      chk("rst cnt", 64'(o_cnt[2]), 64'd0);
      rst = 1'b0; clr();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
